fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 60 ++++++
 rtl/fetch_controller.sv | 103 ++++++++++
 tb/tb_fetch_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch controller.
package fetch_controller_pkg;

    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned INST_W_DEF    = 16;
    localparam int unsigned BUF_DEPTH_DEF = 2;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO between the instruction memory and decode.
module fetch_buffer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned INST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [INST_W-1:0] push_instr,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        count,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INST_W-1:0] head_instr
);

    logic [ADDR_W-1:0] pc_q    [2];
    logic [INST_W-1:0] instr_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            pc_q[wr_ptr_q]    <= push_pc;
            instr_q[wr_ptr_q] <= push_instr;
        end
    end

    assign count      = count_q;
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch front end: issues sequential reads, buffers responses,
// handles redirects (flush + squash) and a halt state left only by redirect.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter int unsigned       INST_W    = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]        buf_count;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_instr;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;

    assign out_valid = (buf_count != 2'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        pop           = out_valid && out_ready;
        push          = inflight_q && !redirect_valid;
        occupancy     = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue         = (state_q == ST_RUN) && !redirect_valid
                        && (occupancy < 3'(BUF_DEPTH));
        inflight_d    = issue;

        if (redirect_valid) begin
            state_d    = ST_RUN;
            fetch_pc_d = redirect_pc;
        end else begin
            if (halt_req) state_d = ST_HALTED;
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
                inflight_pc_d = fetch_pc_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_instr (mem_rdata),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (buf_count),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    // The strobe is gated by reset so nothing is issued while reset is held.
    assign mem_rd_en = issue && !reset;
    assign mem_addr  = mem_rd_en ? fetch_pc_q : '0;
    assign out_pc    = out_valid ? head_pc    : '0;
    assign out_instr = out_valid ? head_instr : '0;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench: memory model, expected-transfer scoreboard and per-cycle spot checks.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        halted;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Instruction memory: data for the strobed address appears one cycle later.
    always @(posedge clk) mem_rdata <= mem_rd_en ? word(mem_addr) : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drives one cycle's inputs just after the rising edge, then waits for the falling edge.
    task automatic drive(input logic rdy, input logic rst, input logic redir,
                         input logic hlt, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        out_ready      = rdy;
        reset          = rst;
        redirect_valid = redir;
        halt_req       = hlt;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    // Scoreboard monitor: every accepted transfer must match the next expected pc/instr.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer_pc", out_pc, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("xfer_pc", out_pc, e);
                    check("xfer_instr", out_instr, word(e));
                end
            end
        end
    end

    initial begin
        // Reset state.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_halted", halted, 0);

        // Straight-line stream 0..5, first valid two cycles after release.
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("c0_mem_rd_en", mem_rd_en, 1);
        check("c0_mem_addr", mem_addr, 16'h0000);
        check("c0_out_valid", out_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("c1_out_valid", out_valid, 0);
        check("c1_mem_addr", mem_addr, 16'h0001);
        for (int c = 2; c < 8; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, 16'(c - 2));
        end
        // Reset with a response in flight; it must be discarded.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("midrst_mem_rd_en", mem_rd_en, 0);
        check("stream_drained", exp_q.size(), 0);

        // Backpressure, redirects, wrap, halt and halt+redirect.
        begin
            logic [15:0] seq [15];
            seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                    16'h0040, 16'h0041, 16'h0042, 16'h0043,
                    16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0010};
            foreach (seq[k]) exp_q.push_back(seq[k]);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("restart_addr", mem_addr, 16'h0000);
        check("restart_no_stale", out_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("restart_no_stale_c1", out_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("restart_pc0", out_pc, 16'h0000);
        for (int c = 3; c < 7; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            check("stall_valid", out_valid, 1);
            check("stall_pc_held", out_pc, 16'h0001);
            check("stall_instr_held", out_instr, word(16'h0001));
            if (c > 3) check("stall_no_fetch", mem_rd_en, 0);
        end
        for (int c = 7; c < 10; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            check("resume_pc", out_pc, 16'(c - 6));
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040);
        check("redir_xfer_pc", out_pc, 16'h0004);
        check("redir_no_issue", mem_rd_en, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("redir_issue_en", mem_rd_en, 1);
        check("redir_issue_addr", mem_addr, 16'h0040);
        check("redir_flushed", out_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("redir_squashed", out_valid, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("redir_first_pc", out_pc, 16'h0040);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        check("redir2_xfer_pc", out_pc, 16'h0043);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("wrap_addr_ffff", mem_addr, 16'hFFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("wrap_addr_0000", mem_addr, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("wrap_out_ffff", out_pc, 16'hFFFF);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("wrap_out_0000", out_pc, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        check("halt_at_pc3", mem_addr, 16'h0003);
        check("wrap_out_0001", out_pc, 16'h0001);
        for (int c = 22; c < 27; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
            check("halted_flag", halted, 1);
            check("halted_no_fetch", mem_rd_en, 0);
            if (c >= 24) check("halted_drained", out_valid, 0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010);
        check("halt_redir_no_issue", mem_rd_en, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("redir_beats_halt", halted, 0);
        check("unhalt_addr", mem_addr, 16'h0010);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("unhalt_out_pc", out_pc, 16'h0010);

        // Fill the buffer, then reset with it full.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("fill_head_pc", out_pc, 16'h0011);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("full_no_fetch", mem_rd_en, 0);
        check("full_valid", out_valid, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("fullrst_out_valid", out_valid, 0);
        check("fullrst_issue_en", mem_rd_en, 1);
        check("fullrst_issue_addr", mem_addr, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("fullrst_first_pc", out_pc, 16'h0000);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
